fp32_acc_sequencer: RTL and testbench
=====================================

# fp32_acc_sequencer

- Streaming accumulator controller that sits directly upstream of the fp32 adder.
- Accepts a vector of IEEE-754 single-precision values over a valid/ready stream.
- Keeps the running sum and feeds it, with each new element, to the adder one pair at a time.
- Collects each adder result and, on the last element, presents the final sum and the element count downstream.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT for add_done before abort.
- CNT_W, 16, width of the element counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  fp32 element.
- in_valid  in  1  element valid.
- in_last  in  1  marks final element of the vector; qualified by in_valid.
- in_ready  out  1  block can accept an element.
- out_sum  out  32  final fp32 sum.
- out_count  out  CNT_W  number of elements accumulated.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- err_timeout  out  1  adder did not respond within TIMEOUT_CYCLES; sticky until next vector's first accept.
- add_a, add_b  out  32  adder operands.
- add_start  out  1  one-cycle start pulse to adder (drives the adder's rst/load input).
- add_z  in  32  adder result.
- add_done  in  1  adder result valid.

## Operation
- States: IDLE, ACCEPT, START, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: sum<=in_data, count<=1, err_timeout<=0.
  - Then OUT if in_last, else ACCEPT. No add is issued for the first element.
- ACCEPT:
  - in_ready=1.
  - On in_valid: opnd<=in_data, last_q<=in_last, then START.
- START:
  - add_start=1 for exactly one cycle.
  - add_a=sum, add_b=opnd; both held stable from START until leaving WAIT.
  - Timer cleared. Next state WAIT.
- WAIT:
  - add_done is sampled only in WAIT; add_done during START is ignored.
  - On add_done=1: sum<=add_z, count<=count+1 (saturating at all-ones), then OUT if last_q, else ACCEPT.
  - If the timer reaches TIMEOUT_CYCLES with no add_done: err_timeout<=1, sum<=0x7FC00000, then OUT.
- OUT:
  - out_valid=1; out_sum=sum, out_count=count, stable while out_valid && !out_ready.
  - On out_ready: IDLE.
- The block does no arithmetic on fp32 values itself. NaN, Inf and signed-zero results from the adder pass through unchanged.
- in_ready=0 in START, WAIT and OUT. The upstream stalls; no element is dropped.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, add_start=0, err_timeout=0.
  - out_sum=0, out_count=0, add_a=0, add_b=0.
  - State IDLE; in_ready rises the cycle after rst deasserts.
- Per-element cost after the first: 1 (ACCEPT handshake) + 1 (START) + L_add (cycles from START to first add_done) + 0.
  - WAIT exits in the same cycle add_done is seen.
- Single-element vector: out_valid one cycle after the IDLE handshake.
- Back-to-back: in_ready reasserts the cycle after add_done is observed (ACCEPT).
- Timer counts WAIT cycles from 1. Abort fires on the cycle it equals TIMEOUT_CYCLES.
- rst mid-operation, in any state:
  - Next cycle is IDLE with reset values; add_start=0.
  - Any in-flight adder result is discarded.
  - A late add_done arriving in IDLE or ACCEPT is ignored.
- Simultaneous in_valid and out_ready in OUT: only the result handshake occurs. The element is accepted in IDLE on the following cycle.

## Structure
- Shared package fp32_pkg: FP32_QNAN=32'h7FC00000, FP32_POS_ZERO=32'h0, and the state encoding.
- Single module, no sub-module; timer and counter are inline.
- The adder is instantiated beside this block by the parent, not inside it.

## Test plan
- Stream 0x3F800000, 0x40000000, 0x40400000 (last): 1.0+2.0+3.0 -> out_sum=0x40C00000, out_count=3, err_timeout=0; exactly 2 add_start pulses.
- Single element 0xC0490FDB with in_last: out_sum=0xC0490FDB, out_count=1, zero add_start pulses, out_valid one cycle after accept.
- Hold out_ready=0 for 10 cycles after out_valid: out_sum, out_count and out_valid stable; in_ready=0 throughout; IDLE entered the cycle after out_ready=1.
- Adder stub that never asserts add_done, 2-element vector: exactly 16 WAIT cycles, then err_timeout=1, out_sum=0x7FC00000, out_count=1; err_timeout clears on the next vector's first accept.
- 0x7F800000 + 0xFF800000 through the real adder: out_sum is NaN (exponent 0xFF, mantissa non-zero), count=2.
- Assert rst during WAIT of the 3rd element: next cycle IDLE with all outputs at reset values; a stray add_done after reset causes no count change; a fresh 2-element vector 1.0+1.0 -> 0x40000000.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 constants and the accumulator-sequencer state encoding.
package fp32_pkg;

   localparam int unsigned FP32_W = 32;

   localparam logic [FP32_W-1:0] FP32_QNAN     = 32'h7FC0_0000;
   localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_OUT    = 3'd4
   } acc_state_e;

endpackage : fp32_pkg

// File: rtl/fp32_acc_sequencer.sv
// Streams fp32 elements into an external adder one pair at a time, keeping the
// running sum, and hands the final sum and element count downstream.
module fp32_acc_sequencer
   import fp32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FP32_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [FP32_W-1:0] out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err_timeout,
   output logic [FP32_W-1:0] add_a,
   output logic [FP32_W-1:0] add_b,
   output logic              add_start,
   input  logic [FP32_W-1:0] add_z,
   input  logic              add_done
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   acc_state_e        state;
   logic [FP32_W-1:0] sum;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_inc;
   logic [TMR_W-1:0]  timer;
   logic              last_q;

   // Element count saturates at all-ones rather than wrapping.
   assign count_inc = (&count) ? count : count + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         add_start   <= 1'b0;
         err_timeout <= 1'b0;
         out_sum     <= FP32_POS_ZERO;
         out_count   <= '0;
         add_a       <= FP32_POS_ZERO;
         add_b       <= FP32_POS_ZERO;
         sum         <= FP32_POS_ZERO;
         count       <= '0;
         timer       <= '0;
         last_q      <= 1'b0;
      end else begin
         add_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               in_ready <= 1'b1;
               // First element seeds the sum directly; no add is issued.
               if (in_valid && in_ready) begin
                  sum         <= in_data;
                  count       <= CNT_W'(1);
                  err_timeout <= 1'b0;
                  if (in_last) begin
                     state     <= ST_OUT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_sum   <= in_data;
                     out_count <= CNT_W'(1);
                  end else begin
                     state <= ST_ACCEPT;
                  end
               end
            end

            ST_ACCEPT: begin
               if (in_valid && in_ready) begin
                  last_q    <= in_last;
                  add_a     <= sum;
                  add_b     <= in_data;
                  add_start <= 1'b1;
                  in_ready  <= 1'b0;
                  state     <= ST_START;
               end
            end

            ST_START: begin
               timer <= TMR_W'(1);
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (add_done) begin
                  sum   <= add_z;
                  count <= count_inc;
                  if (last_q) begin
                     state     <= ST_OUT;
                     out_valid <= 1'b1;
                     out_sum   <= add_z;
                     out_count <= count_inc;
                  end else begin
                     state    <= ST_ACCEPT;
                     in_ready <= 1'b1;
                  end
               end else if (timer == TMR_W'(TIMEOUT_CYCLES)) begin
                  // Adder never answered: abort the vector with a quiet NaN.
                  err_timeout <= 1'b1;
                  sum         <= FP32_QNAN;
                  state       <= ST_OUT;
                  out_valid   <= 1'b1;
                  out_sum     <= FP32_QNAN;
                  out_count   <= count;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule : fp32_acc_sequencer

// File: tb/tb_fp32_acc_sequencer.sv
// Directed bench for fp32_acc_sequencer with a table-driven adder stub.
module tb_fp32_acc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_sum;
   logic [15:0] out_count;
   logic        out_valid;
   logic        out_ready;
   logic        err_timeout;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_start;
   logic [31:0] add_z;
   logic        add_done;

   int n_checks = 0;
   int n_errors = 0;
   int n_starts = 0;

   // Adder stub controls.
   int   add_lat  = 3;
   logic add_dead = 1'b0;
   logic stray_done = 1'b0;
   logic stub_done = 1'b0;
   logic stub_busy = 1'b0;
   int   stub_cnt  = 0;
   logic [31:0] stub_a = '0;
   logic [31:0] stub_b = '0;
   logic [31:0] stub_z = '0;

   assign add_done = stub_done | stray_done;
   assign add_z    = stub_z;

   fp32_acc_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_sum(out_sum), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
      .err_timeout(err_timeout),
      .add_a(add_a), .add_b(add_b), .add_start(add_start),
      .add_z(add_z), .add_done(add_done)
   );

   always #5 clk = ~clk;

   // Hand-computed fp32 sums for the operand pairs this bench uses.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      if      (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      else if (a == 32'h40400000 && b == 32'h40400000) return 32'h40C00000;
      else if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
      else if (a == 32'h7F800000 && b == 32'hFF800000) return 32'h7FC00000;
      else return 32'hDEADBEEF;
   endfunction

   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (add_start) begin
         n_starts  <= n_starts + 1;
         stub_a    <= add_a;
         stub_b    <= add_b;
         stub_cnt  <= add_lat;
         stub_busy <= !add_dead;
      end else if (stub_busy) begin
         if (stub_cnt <= 1) begin
            stub_done <= 1'b1;
            stub_z    <= fp_add(stub_a, stub_b);
            stub_busy <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one element and hold it until the handshake edge has passed.
   task automatic send(input logic [31:0] d, input logic last);
      bit done = 0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (in_ready) done = 1;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) check_eq("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         tick();
         cyc++;
      end
      if (!out_valid) check_eq("wait_out_timeout", 32'd0, 32'd1);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int cyc;
      int s0;
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_in_ready",  32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_add_start", 32'(add_start), 32'd0);
      check_eq("rst_err",       32'(err_timeout), 32'd0);
      check_eq("rst_out_sum",   out_sum, 32'd0);
      check_eq("rst_out_count", 32'(out_count), 32'd0);
      check_eq("rst_add_a",     add_a, 32'd0);
      check_eq("rst_add_b",     add_b, 32'd0);
      rst = 1'b0;
      check_eq("post_rst_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      check_eq("post_rst_in_ready_high", 32'(in_ready), 32'd1);

      // 1.0 + 2.0 + 3.0
      s0 = n_starts;
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b0);
      send(32'h40400000, 1'b1);
      wait_out(cyc);
      check_eq("sum3_value", out_sum, 32'h40C00000);
      check_eq("sum3_count", 32'(out_count), 32'd3);
      check_eq("sum3_err",   32'(err_timeout), 32'd0);
      check_eq("sum3_starts", 32'(n_starts - s0), 32'd2);
      release_out();
      check_eq("sum3_released", 32'(out_valid), 32'd0);
      check_eq("sum3_idle_ready", 32'(in_ready), 32'd1);

      // Single element: result one cycle after the accept, no add issued.
      s0 = n_starts;
      send(32'hC0490FDB, 1'b1);
      check_eq("single_valid", 32'(out_valid), 32'd1);
      check_eq("single_sum",   out_sum, 32'hC0490FDB);
      check_eq("single_count", 32'(out_count), 32'd1);

      // Backpressure: result held stable for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_sum",   out_sum, 32'hC0490FDB);
         check_eq("hold_count", 32'(out_count), 32'd1);
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      end
      check_eq("single_starts", 32'(n_starts - s0), 32'd0);

      // Element offered together with out_ready: only the result handshake happens.
      in_data   = 32'h3F800000;
      in_last   = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("overlap_out_valid", 32'(out_valid), 32'd0);
      check_eq("overlap_idle_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_eq("overlap_accept_valid", 32'(out_valid), 32'd1);
      check_eq("overlap_accept_sum",   out_sum, 32'h3F800000);
      check_eq("overlap_accept_count", 32'(out_count), 32'd1);
      release_out();

      // Dead adder: 16 WAIT cycles then abort with quiet NaN.
      add_dead = 1'b1;
      send(32'h40000000, 1'b0);
      send(32'h3F800000, 1'b1);
      check_eq("to_start_pulse", 32'(add_start), 32'd1);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         tick();
         cyc++;
         if (!out_valid) check_eq("to_in_ready_low", 32'(in_ready), 32'd0);
      end
      check_eq("to_cycles", 32'(cyc), 32'd17);
      check_eq("to_err",   32'(err_timeout), 32'd1);
      check_eq("to_sum",   out_sum, 32'h7FC00000);
      check_eq("to_count", 32'(out_count), 32'd1);
      release_out();
      add_dead = 1'b0;
      check_eq("to_err_sticky", 32'(err_timeout), 32'd1);
      send(32'h3F800000, 1'b1);
      check_eq("to_err_cleared", 32'(err_timeout), 32'd0);
      check_eq("to_next_sum", out_sum, 32'h3F800000);
      release_out();

      // +Inf + -Inf yields NaN, passed through unchanged.
      send(32'h7F800000, 1'b0);
      send(32'hFF800000, 1'b1);
      wait_out(cyc);
      check_eq("inf_exp",  32'(out_sum[30:23]), 32'hFF);
      check_eq("inf_mant_nonzero", 32'(out_sum[22:0] != 23'd0), 32'd1);
      check_eq("inf_count", 32'(out_count), 32'd2);
      release_out();

      // Reset during WAIT of the 3rd element with a slow adder.
      add_lat = 6;
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b0);
      send(32'h40400000, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_in_ready",  32'(in_ready), 32'd0);
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_add_start", 32'(add_start), 32'd0);
      check_eq("mid_rst_err",       32'(err_timeout), 32'd0);
      check_eq("mid_rst_out_sum",   out_sum, 32'd0);
      check_eq("mid_rst_out_count", 32'(out_count), 32'd0);
      check_eq("mid_rst_add_a",     add_a, 32'd0);
      check_eq("mid_rst_add_b",     add_b, 32'd0);
      for (int i = 0; i < 8; i++) tick();
      check_eq("late_done_no_out", 32'(out_valid), 32'd0);
      check_eq("late_done_idle",   32'(in_ready), 32'd1);

      // Fresh 1.0 + 1.0 with a stray add_done while in ACCEPT.
      add_lat = 2;
      send(32'h3F800000, 1'b0);
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      check_eq("stray_no_out", 32'(out_valid), 32'd0);
      send(32'h3F800000, 1'b1);
      wait_out(cyc);
      check_eq("fresh_sum",   out_sum, 32'h40000000);
      check_eq("fresh_count", 32'(out_count), 32'd2);
      check_eq("fresh_err",   32'(err_timeout), 32'd0);
      release_out();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fp32_acc_sequencer
